// File: rtl/div4_operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : div4_operand_sequencer
//  Purpose  : Sequential front-end for a combinational W-bit divider. It takes
//             dividend/divisor pairs over a valid/ready handshake, drives the
//             divider from registers, waits SETTLE cycles, then captures the
//             quotient/remainder and offers them over a second handshake.
//             A zero divisor is answered locally (Q = all ones, R = dividend)
//             and the divider output is never sampled for it.
//  Revision : 1.0  initial release
// ============================================================================
module div4_operand_sequencer #(
  parameter int W      = 4,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_dividend,
  input  logic [W-1:0] in_divisor,
  output logic [W-1:0] div_a,
  output logic [W-1:0] div_b,
  input  logic [W-1:0] div_q,
  input  logic [W-1:0] div_r,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_q,
  output logic [W-1:0] out_r,
  output logic         out_dbz
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // The wait counter is loaded with SETTLE-1, so sampling lands exactly
  // SETTLE edges after the divider inputs were registered.
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  state_t       state_q, state_d;
  logic [3:0]   cnt_q,   cnt_d;
  logic [W-1:0] a_q,     a_d;
  logic [W-1:0] b_q,     b_d;
  logic [W-1:0] q_q,     q_d;
  logic [W-1:0] r_q,     r_d;
  logic         dbz_q,   dbz_d;

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state and datapath update; every register holds unless its state
  // explicitly changes it, which keeps the result stable under backpressure.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        // in_ready is high throughout IDLE, so in_valid alone means accept.
        if (in_valid) begin
          a_d = in_dividend;
          b_d = in_divisor;
          if (in_divisor == '0) begin
            q_d     = '1;
            r_d     = in_dividend;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          q_d     = div_q;
          r_d     = div_r;
          dbz_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // A new pair is only taken from IDLE, one edge after the handshake.
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake flags depend on state only, never on in_valid or out_ready.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign div_a     = a_q;
  assign div_b     = b_q;
  assign out_q     = q_q;
  assign out_r     = r_q;
  assign out_dbz   = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_div4_operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div4_operand_sequencer
//  Purpose  : Self-checking bench. Lane 0 runs SETTLE=1, lane 1 SETTLE=3.
//             Each lane has a bench-side divider whose outputs are wrong
//             until the operands have been stable long enough, and a
//             transaction-level model checked every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_div4_operand_sequencer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v        [2];
  logic       in_valid_v   [2];
  logic       in_ready_v   [2];
  logic [3:0] in_dividend_v[2];
  logic [3:0] in_divisor_v [2];
  logic [3:0] div_a_v      [2];
  logic [3:0] div_b_v      [2];
  logic [3:0] div_q_v      [2];
  logic [3:0] div_r_v      [2];
  logic       out_valid_v  [2];
  logic       out_ready_v  [2];
  logic [3:0] out_q_v      [2];
  logic [3:0] out_r_v      [2];
  logic       out_dbz_v    [2];

  int n_vec = 0;
  int n_err = 0;

  function automatic int settle_of(input int l);
    return (l == 0) ? 1 : 3;
  endfunction

  for (genvar l = 0; l < 2; l++) begin : g_lane
    localparam int SET = (l == 0) ? 1 : 3;

    div4_operand_sequencer #(.W(4), .SETTLE(SET)) u_dut (
      .clk        (clk),
      .rst        (rst_v[l]),
      .in_valid   (in_valid_v[l]),
      .in_ready   (in_ready_v[l]),
      .in_dividend(in_dividend_v[l]),
      .in_divisor (in_divisor_v[l]),
      .div_a      (div_a_v[l]),
      .div_b      (div_b_v[l]),
      .div_q      (div_q_v[l]),
      .div_r      (div_r_v[l]),
      .out_valid  (out_valid_v[l]),
      .out_ready  (out_ready_v[l]),
      .out_q      (out_q_v[l]),
      .out_r      (out_r_v[l]),
      .out_dbz    (out_dbz_v[l])
    );

    // Divider model: results become correct only once the operands have
    // been stable for SET-1 full cycles; before that they are inverted.
    int         age  = 0;
    logic [7:0] prev = 8'd0;
    always @(negedge clk) begin
      if ({div_a_v[l], div_b_v[l]} != prev) begin
        prev = {div_a_v[l], div_b_v[l]};
        age  = 0;
      end else if (age < 100) begin
        age++;
      end
    end
    wire logic       early = (age < SET - 1);
    wire logic [3:0] tq    = div_a_v[l] / div_b_v[l];
    wire logic [3:0] tr    = div_a_v[l] % div_b_v[l];
    assign div_q_v[l] = (div_b_v[l] == 4'd0) ? 4'h5 : (early ? ~tq : tq);
    assign div_r_v[l] = (div_b_v[l] == 4'd0) ? 4'hA : (early ? ~tr : tr);
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model -----------------
  int m_ok  [2] = '{0, 0};
  int m_idle[2], m_done[2], m_left[2];
  int m_a[2], m_b[2], m_q[2], m_r[2], m_dbz[2];

  // Compare on the falling edge, then advance the model by the coming
  // rising edge using the (stable) inputs the DUT will see there.
  always @(negedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (m_ok[l] != 0) begin
        check($sformatf("lane%0d in_ready", l),  int'(in_ready_v[l]),  m_idle[l]);
        check($sformatf("lane%0d out_valid", l), int'(out_valid_v[l]), m_done[l]);
        check($sformatf("lane%0d out_q", l),     int'(out_q_v[l]),     m_q[l]);
        check($sformatf("lane%0d out_r", l),     int'(out_r_v[l]),     m_r[l]);
        check($sformatf("lane%0d out_dbz", l),   int'(out_dbz_v[l]),   m_dbz[l]);
        check($sformatf("lane%0d div_a", l),     int'(div_a_v[l]),     m_a[l]);
        check($sformatf("lane%0d div_b", l),     int'(div_b_v[l]),     m_b[l]);
      end
      if (rst_v[l]) begin
        m_ok[l] = 1; m_idle[l] = 1; m_done[l] = 0; m_left[l] = 0;
        m_a[l] = 0; m_b[l] = 0; m_q[l] = 0; m_r[l] = 0; m_dbz[l] = 0;
      end else if (m_ok[l] != 0) begin
        if (m_idle[l] != 0) begin
          if (in_valid_v[l]) begin
            m_a[l]    = int'(in_dividend_v[l]);
            m_b[l]    = int'(in_divisor_v[l]);
            m_idle[l] = 0;
            if (m_b[l] == 0) begin
              m_q[l] = 15; m_r[l] = m_a[l]; m_dbz[l] = 1; m_done[l] = 1;
            end else begin
              m_left[l] = settle_of(l);
            end
          end
        end else if (m_done[l] != 0) begin
          if (out_ready_v[l]) begin
            m_done[l] = 0; m_idle[l] = 1;
          end
        end else begin
          m_left[l]--;
          if (m_left[l] == 0) begin
            m_q[l] = m_a[l] / m_b[l]; m_r[l] = m_a[l] % m_b[l];
            m_dbz[l] = 0; m_done[l] = 1;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int l, input int a, input int b);
    int n = 0;
    in_dividend_v[l] = 4'(a);
    in_divisor_v[l]  = 4'(b);
    in_valid_v[l]    = 1'b1;
    while (!in_ready_v[l] && n < 50) begin
      tick();
      n++;
    end
    check($sformatf("lane%0d accept_ready", l), int'(in_ready_v[l]), 1);
    tick();
    in_valid_v[l] = 1'b0;
  endtask

  task automatic wait_valid(input int l, output int k);
    k = 0;
    while (!out_valid_v[l] && k < 50) begin
      tick();
      k++;
    end
  endtask

  task automatic consume(input int l);
    out_ready_v[l] = 1'b1;
    tick();
    out_ready_v[l] = 1'b0;
  endtask

  task automatic expect_res(input string tag, input int l, input int q,
                            input int r, input int dbz);
    check({tag, " valid"}, int'(out_valid_v[l]), 1);
    check({tag, " q"},     int'(out_q_v[l]),     q);
    check({tag, " r"},     int'(out_r_v[l]),     r);
    check({tag, " dbz"},   int'(out_dbz_v[l]),   dbz);
  endtask

  task automatic expect_reset(input string tag, input int l);
    check({tag, " in_ready"},  int'(in_ready_v[l]),  1);
    check({tag, " out_valid"}, int'(out_valid_v[l]), 0);
    check({tag, " out_q"},     int'(out_q_v[l]),     0);
    check({tag, " out_r"},     int'(out_r_v[l]),     0);
    check({tag, " out_dbz"},   int'(out_dbz_v[l]),   0);
    check({tag, " div_a"},     int'(div_a_v[l]),     0);
    check({tag, " div_b"},     int'(div_b_v[l]),     0);
  endtask

  // ---------------- directed and random stimulus ----------------
  initial begin
    int k;
    for (int l = 0; l < 2; l++) begin
      rst_v[l] = 1'b1; in_valid_v[l] = 1'b0; out_ready_v[l] = 1'b0;
      in_dividend_v[l] = 4'd0; in_divisor_v[l] = 4'd0;
    end
    tick();
    tick();
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;
    expect_reset("lane0 reset", 0);
    expect_reset("lane1 reset", 1);

    // 13/4, SETTLE=1
    send(0, 13, 4);
    wait_valid(0, k);
    check("13/4 latency", k, 1);
    expect_res("13/4", 0, 3, 1, 0);
    check("13/4 div_a", int'(div_a_v[0]), 13);
    check("13/4 div_b", int'(div_b_v[0]), 4);
    consume(0);
    check("13/4 div_a held", int'(div_a_v[0]), 13);
    check("13/4 div_b held", int'(div_b_v[0]), 4);

    // 9/0 is answered locally one cycle after accept
    send(0, 9, 0);
    wait_valid(0, k);
    check("9/0 latency", k, 0);
    expect_res("9/0", 0, 15, 9, 1);
    consume(0);

    // 15/1 then 3/7 with in_valid held high throughout
    out_ready_v[0] = 1'b1;
    in_dividend_v[0] = 4'd15; in_divisor_v[0] = 4'd1; in_valid_v[0] = 1'b1;
    tick();
    check("b2b busy in_ready", int'(in_ready_v[0]), 0);
    in_dividend_v[0] = 4'd3; in_divisor_v[0] = 4'd7;
    tick();
    expect_res("b2b first", 0, 15, 0, 0);
    check("b2b done in_ready", int'(in_ready_v[0]), 0);
    tick();
    check("b2b idle in_ready", int'(in_ready_v[0]), 1);
    check("b2b idle out_valid", int'(out_valid_v[0]), 0);
    tick();
    check("b2b second accepted", int'(div_a_v[0]), 3);
    check("b2b second in_ready", int'(in_ready_v[0]), 0);
    tick();
    expect_res("b2b second", 0, 0, 3, 0);
    in_valid_v[0] = 1'b0;
    tick();
    out_ready_v[0] = 1'b0;

    // 14/3 under backpressure
    send(0, 14, 3);
    wait_valid(0, k);
    for (int i = 0; i < 5; i++) begin
      expect_res("bp hold", 0, 4, 2, 0);
      check("bp in_ready", int'(in_ready_v[0]), 0);
      tick();
    end
    consume(0);
    check("bp after in_ready", int'(in_ready_v[0]), 1);
    check("bp after out_valid", int'(out_valid_v[0]), 0);

    // SETTLE=3: 10/3 must not be sampled before the divider settles
    send(1, 10, 3);
    wait_valid(1, k);
    check("10/3 latency", k, 3);
    expect_res("10/3", 1, 3, 1, 0);
    consume(1);

    // reset during WAIT, then during DONE
    send(1, 5, 2);
    tick();
    rst_v[1] = 1'b1;
    tick();
    rst_v[1] = 1'b0;
    expect_reset("rst in WAIT", 1);
    send(1, 7, 0);
    check("pre-rst DONE valid", int'(out_valid_v[1]), 1);
    rst_v[1] = 1'b1;
    tick();
    rst_v[1] = 1'b0;
    expect_reset("rst in DONE", 1);
    send(1, 6, 2);
    wait_valid(1, k);
    check("6/2 latency", k, 3);
    expect_res("6/2", 1, 3, 0, 0);
    consume(1);

    // random traffic on both lanes; the model checks every cycle
    for (int i = 0; i < 600; i++) begin
      for (int l = 0; l < 2; l++) begin
        in_valid_v[l]    = ($urandom_range(0, 2) != 0);
        in_dividend_v[l] = 4'($urandom_range(0, 15));
        in_divisor_v[l]  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        out_ready_v[l]   = ($urandom_range(0, 1) != 0);
        rst_v[l]         = ($urandom_range(0, 99) == 0);
      end
      tick();
    end
    for (int l = 0; l < 2; l++) begin
      in_valid_v[l] = 1'b0; out_ready_v[l] = 1'b0; rst_v[l] = 1'b0;
    end
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
